tone_gen: RTL

Multi-channel, parametrised successor to the single-channel square-wave generator. Provides NUM_CH independent rectangular-wave outputs, each with a programmable period and duty (high-time). Period/duty changes are double-buffered and take effect only at a period boundary, so outputs never glitch. Sits on the J1a I/O bus as a write-only peripheral driving audio/beeper and PWM pins.

---
 rtl/tone_gen.sv | 111 +++++++++++
 1 files changed

// File: rtl/tone_gen.sv
// tone_gen: NUM_CH independent rectangular-wave channels with double-buffered period/duty.
// Define TONE_GEN_WRAP_EN to add the per-channel `wrap` boundary pulse output.

module tone_ch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic             sel,
  input  logic [WIDTH-1:0] data,
  output logic             out
`ifdef TONE_GEN_WRAP_EN
  ,
  output logic             wrap
`endif
);
  logic [WIDTH-1:0] pp, pd, p, d, cnt;
  logic             run, at_end;

  assign run    = (p != '0) && en;
  assign at_end = (cnt == p - WIDTH'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pp  <= '0;
      pd  <= '0;
      p   <= '0;
      d   <= '0;
      cnt <= '0;
      out <= 1'b0;
    end else begin
      if (we && !sel) pp <= data;
      if (we && sel)  pd <= data;
      // Idle channels track the shadows every cycle; running ones only at the wrap edge.
      if (p == '0) begin
        p   <= pp;
        d   <= pd;
        cnt <= '0;
      end else if (en) begin
        if (at_end) begin
          cnt <= '0;
          p   <= pp;
          d   <= pd;
        end else begin
          cnt <= cnt + WIDTH'(1);
        end
      end
      out <= run && (cnt < d);
    end
  end

`ifdef TONE_GEN_WRAP_EN
  always_ff @(posedge clk) begin
    if (reset) wrap <= 1'b0;
    else       wrap <= run && at_end;
  end
`endif

endmodule

module tone_gen #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4,
  parameter int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              wr_en,
  input  logic [CHW-1:0]    wr_addr,
  input  logic              wr_sel,
  input  logic [WIDTH-1:0]  wr_data,
  output logic [NUM_CH-1:0] out
`ifdef TONE_GEN_WRAP_EN
  ,
  output logic [NUM_CH-1:0] wrap
`endif
);
  typedef struct packed {
    logic             vld;
    logic             sel;
    logic [CHW-1:0]   addr;
    logic [WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t           req;
  logic [NUM_CH-1:0] we;

  assign req = '{vld: wr_en, sel: wr_sel, addr: wr_addr, data: wr_data};

  // Full-width address compare, so out-of-range addresses never alias onto a channel.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign we[i] = req.vld && (req.addr == CHW'(i));
    tone_ch #(.WIDTH(WIDTH)) u_ch (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .we   (we[i]),
      .sel  (req.sel),
      .data (req.data),
      .out  (out[i])
`ifdef TONE_GEN_WRAP_EN
      ,
      .wrap (wrap[i])
`endif
    );
  end

endmodule
